serial_xor_reduce: RTL and testbench

- Multi-cycle XOR-reduction (parity) engine, the parametrised successor to the single-bit mux-built XOR gate.
- Accepts a WIDTH-bit word over a valid/ready handshake and folds STEP bits per cycle into a running XOR.
- Presents the even or odd parity bit on a valid/ready output handshake.
- Used wherever word parity is needed and area matters more than latency: datapath checkers and serial framers.

---
 rtl/serial_xor_reduce_if.sv | 24 ++
 rtl/serial_xor_reduce.sv | 80 ++++++++
 tb/tb_serial_xor_reduce.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_xor_reduce_if.sv
// Handshake bundle for serial_xor_reduce: word input side, parity output side, busy flag.
// WIDTH must match the WIDTH of the serial_xor_reduce it connects to.
interface serial_xor_reduce_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_odd;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             busy;

  modport master (
    output in_valid, in_data, in_odd, out_ready,
    input  in_ready, out_valid, out_parity, busy
  );

  modport slave (
    input  in_valid, in_data, in_odd, out_ready,
    output in_ready, out_valid, out_parity, busy
  );
endinterface

// File: rtl/serial_xor_reduce.sv
// Serial parity engine: folds STEP bits per cycle, WIDTH/STEP cycles accept-to-result.
// One word in flight; in_ready only in IDLE, result held in DONE until out_ready.
module serial_xor_reduce #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input logic            clk,
  input logic            rst,
  serial_xor_reduce_if.slave bus
);
  localparam int N  = (STEP >= 1) ? (WIDTH / STEP) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  generate
    if (WIDTH < 1 || STEP < 1) begin : g_bad_range
      $error("serial_xor_reduce: WIDTH and STEP must both be >= 1");
    end else if ((WIDTH % STEP) != 0) begin : g_bad_div
      $error("serial_xor_reduce: STEP must divide WIDTH exactly");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             acc;
  logic             odd_l;
  logic             parity_q;
  logic             fold;

  assign fold = ^sreg[STEP-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
      odd_l    <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg  <= bus.in_data;
            odd_l <= bus.in_odd;
            acc   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc  <= acc ^ fold;
          sreg <= sreg >> STEP;
          cnt  <= cnt + 1'b1;
          // Final chunk: register the result directly so out_parity is stable in DONE.
          if (cnt == LAST) begin
            parity_q <= acc ^ fold ^ odd_l;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_parity = parity_q;
endmodule

// File: tb/tb_serial_xor_reduce.sv
// Scoreboard bench: main 16/4 instance for directed tests, five instances for the parameter sweep.
module tb_serial_xor_reduce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  serial_xor_reduce_if #(.WIDTH(16)) m_if ();
  serial_xor_reduce #(.WIDTH(16), .STEP(4)) dut (.clk(clk), .rst(rst), .bus(m_if));

  bit exp_q[$];

  // Sweep instances share one stimulus; each keeps its own expected queue.
  logic        sw_valid = 1'b0;
  logic [15:0] sw_data  = '0;
  logic        sw_odd   = 1'b0;
  logic        sw_ready = 1'b1;
  logic [4:0]  sw_ov, sw_par, sw_rdy;
  int          sw_n[5] = '{16, 8, 4, 1, 1};
  bit          sw_q[5][$];

  serial_xor_reduce_if #(.WIDTH(16)) s0_if ();
  serial_xor_reduce_if #(.WIDTH(16)) s1_if ();
  serial_xor_reduce_if #(.WIDTH(16)) s2_if ();
  serial_xor_reduce_if #(.WIDTH(16)) s3_if ();
  serial_xor_reduce_if #(.WIDTH(8))  s4_if ();
  serial_xor_reduce #(.WIDTH(16), .STEP(1))  u_s0 (.clk(clk), .rst(rst), .bus(s0_if));
  serial_xor_reduce #(.WIDTH(16), .STEP(2))  u_s1 (.clk(clk), .rst(rst), .bus(s1_if));
  serial_xor_reduce #(.WIDTH(16), .STEP(4))  u_s2 (.clk(clk), .rst(rst), .bus(s2_if));
  serial_xor_reduce #(.WIDTH(16), .STEP(16)) u_s3 (.clk(clk), .rst(rst), .bus(s3_if));
  serial_xor_reduce #(.WIDTH(8),  .STEP(8))  u_s4 (.clk(clk), .rst(rst), .bus(s4_if));

  assign s0_if.in_valid = sw_valid; assign s0_if.in_data = sw_data;      assign s0_if.in_odd = sw_odd; assign s0_if.out_ready = sw_ready;
  assign s1_if.in_valid = sw_valid; assign s1_if.in_data = sw_data;      assign s1_if.in_odd = sw_odd; assign s1_if.out_ready = sw_ready;
  assign s2_if.in_valid = sw_valid; assign s2_if.in_data = sw_data;      assign s2_if.in_odd = sw_odd; assign s2_if.out_ready = sw_ready;
  assign s3_if.in_valid = sw_valid; assign s3_if.in_data = sw_data;      assign s3_if.in_odd = sw_odd; assign s3_if.out_ready = sw_ready;
  assign s4_if.in_valid = sw_valid; assign s4_if.in_data = sw_data[7:0]; assign s4_if.in_odd = sw_odd; assign s4_if.out_ready = sw_ready;
  assign sw_ov  = {s4_if.out_valid,  s3_if.out_valid,  s2_if.out_valid,  s1_if.out_valid,  s0_if.out_valid};
  assign sw_par = {s4_if.out_parity, s3_if.out_parity, s2_if.out_parity, s1_if.out_parity, s0_if.out_parity};
  assign sw_rdy = {s4_if.in_ready,   s3_if.in_ready,   s2_if.in_ready,   s1_if.in_ready,   s0_if.in_ready};

  // Presents one word at a negedge and returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] d, input logic odd);
    int guard = 0;
    while (m_if.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (m_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", m_if.in_ready);
    end
    m_if.in_data  = d;
    m_if.in_odd   = odd;
    m_if.in_valid = 1'b1;
    exp_q.push_back((^d) ^ odd);
    @(posedge clk);
    @(negedge clk);
    m_if.in_valid = 1'b0;
  endtask

  // Counts negedges from the accept until out_valid; lat == k means valid after edge E_k.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (m_if.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0 || m_if.busy !== 1'b0 || m_if.out_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b par=%b required 1 0 0 0",
               m_if.in_ready, m_if.out_valid, m_if.busy, m_if.out_parity);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    bit e;
    send(16'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m_if.in_ready !== 1'b0 || m_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy: cyc=%0d rdy=%b busy=%b required 0 1", k, m_if.in_ready, m_if.busy);
      end
      if (k < 3) @(negedge clk);
    end
    wait_valid(lat);
    lat = lat + 3;
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 4", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (m_if.out_parity !== e) begin
      errors++;
      $display("FAIL basic_parity: got %b required %b", m_if.out_parity, e);
    end
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.out_ready = 1'b0;
    checks++;
    if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0 || m_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: rdy=%b vld=%b busy=%b required 1 0 0", m_if.in_ready, m_if.out_valid, m_if.busy);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pd[3] = '{16'hFFFF, 16'hFFFF, 16'h8421};
    logic        po[3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    bit e;
    for (int i = 0; i < 3; i++) begin
      send(pd[i], po[i]);
      wait_valid(lat);
      e = exp_q.pop_front();
      checks++;
      if (m_if.out_valid !== 1'b1 || m_if.out_parity !== e || lat != 4) begin
        errors++;
        $display("FAIL pattern_%0d: vld=%b par=%b lat=%0d required 1 %b 4", i, m_if.out_valid, m_if.out_parity, lat, e);
      end
      m_if.out_ready = 1'b1;
      @(negedge clk);
      m_if.out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit e;
    send(16'h0003, 1'b0);
    wait_valid(lat);
    e = exp_q.pop_front();
    for (int k = 0; k < 10; k++) begin
      m_if.in_valid = k[0];
      m_if.in_data  = 16'($urandom);
      m_if.in_odd   = 1'($urandom);
      checks++;
      if (m_if.out_valid !== 1'b1 || m_if.out_parity !== e || m_if.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cyc=%0d vld=%b par=%b rdy=%b required 1 %b 0",
                 k, m_if.out_valid, m_if.out_parity, m_if.in_ready, e);
      end
      @(negedge clk);
    end
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.out_ready = 1'b0;
    checks++;
    if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b rdy=%b required 0 1", m_if.out_valid, m_if.in_ready);
    end
    @(negedge clk);
    checks++;
    if (m_if.out_valid !== 1'b0 || m_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_single: vld=%b busy=%b required 0 0", m_if.out_valid, m_if.busy);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    bit e;
    send(16'h0001, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_if.out_valid !== 1'b0 || m_if.busy !== 1'b0 || m_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: vld=%b busy=%b rdy=%b required 0 0 1", m_if.out_valid, m_if.busy, m_if.in_ready);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (m_if.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard: cyc=%0d vld=%b required 0", k, m_if.out_valid);
      end
      @(negedge clk);
    end
    send(16'h0007, 1'b0);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++;
    if (m_if.out_parity !== e || lat != 4) begin
      errors++;
      $display("FAIL after_reset: par=%b lat=%0d required %b 4", m_if.out_parity, lat, e);
    end
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[3] = '{16'h1234, 16'hA5A5, 16'h0F01};
    logic        o[3] = '{1'b0, 1'b1, 1'b0};
    int acc_cyc[3];
    int idx = 0;
    int got = 0;
    bit e;
    m_if.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (m_if.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result par=%b", m_if.out_parity);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (m_if.out_parity !== e) begin
            errors++;
            $display("FAIL b2b_parity: word=%0d got %b required %b", got - 1, m_if.out_parity, e);
          end
        end
      end
      if (idx < 3) begin
        m_if.in_valid = 1'b1;
        m_if.in_data  = w[idx];
        m_if.in_odd   = o[idx];
        if (m_if.in_ready === 1'b1) begin
          exp_q.push_back((^w[idx]) ^ o[idx]);
          acc_cyc[idx] = c;
          idx++;
        end
      end else begin
        m_if.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    m_if.out_ready = 1'b0;
    checks++;
    if (idx != 3 || got != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d results=%0d left=%0d required 3 3 0", idx, got, exp_q.size());
    end
    for (int i = 1; i < idx; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
        errors++;
        $display("FAIL b2b_spacing: gap=%0d required 6", acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_sweep();
    bit done[5];
    bit e;
    int guard;
    sw_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      guard = 0;
      while (sw_rdy !== 5'h1F && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (sw_rdy !== 5'h1F) begin
        errors++;
        $display("FAIL sweep_ready: word=%0d rdy=%b required 11111", n, sw_rdy);
      end
      sw_data  = 16'($urandom);
      sw_odd   = 1'($urandom);
      sw_valid = 1'b1;
      for (int i = 0; i < 4; i++) sw_q[i].push_back((^sw_data) ^ sw_odd);
      sw_q[4].push_back((^sw_data[7:0]) ^ sw_odd);
      @(posedge clk);
      @(negedge clk);
      sw_valid = 1'b0;
      for (int i = 0; i < 5; i++) done[i] = 1'b0;
      for (int c = 0; c < 24; c++) begin
        for (int i = 0; i < 5; i++) begin
          if (!done[i] && sw_ov[i] === 1'b1) begin
            done[i] = 1'b1;
            e = sw_q[i].pop_front();
            checks++;
            if (c != sw_n[i]) begin
              errors++;
              $display("FAIL sweep_latency: inst=%0d word=%0d got %0d required %0d", i, n, c, sw_n[i]);
            end
            checks++;
            if (sw_par[i] !== e) begin
              errors++;
              $display("FAIL sweep_parity: inst=%0d data=%h odd=%b got %b required %b", i, sw_data, sw_odd, sw_par[i], e);
            end
          end
        end
        @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
        if (!done[i]) begin
          checks++;
          errors++;
          $display("FAIL sweep_timeout: inst=%0d word=%0d no out_valid", i, n);
          void'(sw_q[i].pop_front());
        end
      end
    end
  endtask

  initial begin
    m_if.in_valid  = 1'b0;
    m_if.in_data   = '0;
    m_if.in_odd    = 1'b0;
    m_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
